// File: rtl/fwft_sync_fifo.sv
// Single-clock show-ahead FIFO: DEPTH-entry RAM feeding one output register, with occupancy count and almost-full flag.
// Optional sticky overflow/underflow flags are built only when FWFT_FIFO_ERR_FLAGS_EN is defined.
module fwft_sync_fifo #(
    parameter int WIDTH            = 89,
    parameter int DEPTH            = 8,
    parameter int PROG_FULL_THRESH = 3
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic [WIDTH-1:0]               din,
    input  logic                           wr_en,
    output logic                           full,
    output logic                           prog_full,
    output logic [WIDTH-1:0]               dout,
    output logic                           valid,
    input  logic                           rd_en,
    output logic                           empty,
    output logic [$clog2(DEPTH+2)-1:0]     data_count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(PROG_FULL_THRESH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wp_r;
    logic [AW-1:0]    rp_r;
    logic [CW-1:0]    ram_cnt_r;
    logic [WIDTH-1:0] dout_r;
    logic             valid_r;

    logic             full_s;
    logic             wr_acc_s;
    logic             pop_s;
    logic             load_s;
    logic [CW-1:0]    ram_cnt_nxt_s;

    // Handshake decode; full looks only at registered state, so a same-cycle pop never frees a write.
    always_comb begin
        full_s   = (ram_cnt_r == DEPTH_C);
        wr_acc_s = wr_en & ~full_s;
        pop_s    = rd_en & valid_r;
        load_s   = (~valid_r | pop_s) & (ram_cnt_r != {CW{1'b0}});
    end

    // RAM occupancy next-state.
    always_comb begin
        ram_cnt_nxt_s = ram_cnt_r;
        case ({wr_acc_s, load_s})
            2'b10:   ram_cnt_nxt_s = ram_cnt_r + CW'(1);
            2'b01:   ram_cnt_nxt_s = ram_cnt_r - CW'(1);
            default: ram_cnt_nxt_s = ram_cnt_r;
        endcase
    end

    // Storage array write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !srst) begin
            mem_r[wp_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            wp_r      <= {AW{1'b0}};
            rp_r      <= {AW{1'b0}};
            ram_cnt_r <= {CW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wp_r <= wp_r + AW'(1);
            end
            if (load_s) begin
                rp_r <= rp_r + AW'(1);
            end
            ram_cnt_r <= ram_cnt_nxt_s;
        end
    end

    // Show-ahead output register: refilled whenever it is empty or being consumed.
    always_ff @(posedge clk) begin
        if (srst) begin
            dout_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (load_s) begin
            dout_r  <= mem_r[rp_r];
            valid_r <= 1'b1;
        end else if (pop_s) begin
            valid_r <= 1'b0;
        end
    end

`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end
            if (rd_en && !valid_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign full       = full_s;
    assign dout       = dout_r;
    assign valid      = valid_r;
    assign empty      = ~valid_r;
    assign data_count = ram_cnt_r + {{(CW-1){1'b0}}, valid_r};
    assign prog_full  = (data_count >= THRESH_C);

endmodule
